// File: rtl/spectrum_framer_pkg.sv
// spectrum_framer_pkg
// Shared types and constants for the spectrum framer block.
//   ampl_t    : signed magnitude word stored in the frame buffers
//   bin_idx_t : index of a bin inside an NFFT-point frame
//   state_t   : framer FSM states
//   AMPL_MAX  : saturation limit for a stored magnitude
// Build-wide defaults come from NFFT, FREQS, SFFT_OUTPUT_WIDTH and
// INPUT_AMPL_WIDTH; each falls back to a standalone value when the
// surrounding build does not define it.

`ifndef NFFT
`define NFFT 32
`endif
`ifndef FREQS
`define FREQS 16
`endif
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 16
`endif
`ifndef INPUT_AMPL_WIDTH
`define INPUT_AMPL_WIDTH 16
`endif

package spectrum_framer_pkg;

  localparam int NFFT_DEF   = `NFFT;
  localparam int FREQS_DEF  = `FREQS;
  localparam int IN_W_DEF   = `SFFT_OUTPUT_WIDTH;
  localparam int AMPL_W_DEF = `INPUT_AMPL_WIDTH;

  typedef logic signed [AMPL_W_DEF-1:0] ampl_t;
  typedef logic [$clog2(NFFT_DEF)-1:0]  bin_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam ampl_t AMPL_MAX = ampl_t'((64'd1 << (AMPL_W_DEF - 1)) - 64'd1);

endpackage

// File: rtl/spectrum_framer_if.sv
// spectrum_framer_if
// Bundles the serial bin stream from the SFFT and the parallel frame
// published towards the peak finder.
//   bin_valid, bin_sop, bin_re, bin_im : serial complex bin stream
//   fft_in[FREQS]                      : published magnitude frame
//   valid_in                           : one-cycle strobe, new frame in fft_in
//   frame_drop                         : one-cycle strobe, a frame was lost
// Handshake: the bin stream is push-only. A bin is transferred on every
// rising edge where bin_valid is high; there is no ready, the framer always
// accepts. bin_sop is meaningful only together with bin_valid. On the output
// side valid_in is a single-cycle strobe with no back-pressure; fft_in is
// stable from that strobe until the next one.
// Modports: master = bin source / frame sink, slave = the framer.

interface spectrum_framer_if #(
  parameter int IN_W   = 16,
  parameter int AMPL_W = 16,
  parameter int FREQS  = 16
);
  logic                     bin_valid;
  logic                     bin_sop;
  logic signed [IN_W-1:0]   bin_re;
  logic signed [IN_W-1:0]   bin_im;
  logic signed [AMPL_W-1:0] fft_in [FREQS];
  logic                     valid_in;
  logic                     frame_drop;

  modport master (
    output bin_valid, bin_sop, bin_re, bin_im,
    input  fft_in, valid_in, frame_drop
  );

  modport slave (
    input  bin_valid, bin_sop, bin_re, bin_im,
    output fft_in, valid_in, frame_drop
  );
endinterface

// File: rtl/spectrum_framer_l1_magnitude.sv
// l1_magnitude
// Combinational L1 magnitude |re| + |im| of one complex bin, saturated to
// the largest positive AMPL_W-bit signed value.
//   re, im : signed IN_W-bit bin value
//   mag    : signed AMPL_W-bit saturated magnitude (never negative)

module l1_magnitude #(
  parameter int IN_W   = 16,
  parameter int AMPL_W = 16
) (
  input  logic signed [IN_W-1:0]   re,
  input  logic signed [IN_W-1:0]   im,
  output logic signed [AMPL_W-1:0] mag
);

  // Working width wide enough for both the raw sum and the limit.
  localparam int EW = (IN_W + 1 > AMPL_W) ? IN_W + 1 : AMPL_W;
  localparam logic [EW-1:0] LIMIT = EW'((64'd1 << (AMPL_W - 1)) - 64'd1);

  logic [IN_W-1:0] re_u;
  logic [IN_W-1:0] im_u;
  logic [IN_W-1:0] abs_re;
  logic [IN_W-1:0] abs_im;
  logic [IN_W:0]   sum;
  logic [EW-1:0]   sum_ext;
  logic [EW-1:0]   sat;

  assign re_u = re;
  assign im_u = im;

  // Two's-complement negate read as unsigned: the most negative input
  // becomes exactly 2^(IN_W-1), so no wrap.
  assign abs_re = re_u[IN_W-1] ? (~re_u + IN_W'(1)) : re_u;
  assign abs_im = im_u[IN_W-1] ? (~im_u + IN_W'(1)) : im_u;

  assign sum     = {1'b0, abs_re} + {1'b0, abs_im};
  assign sum_ext = EW'(sum);
  assign sat     = (sum_ext > LIMIT) ? LIMIT : sum_ext;
  assign mag     = $signed(sat[AMPL_W-1:0]);

endmodule

// File: rtl/spectrum_framer.sv
// spectrum_framer
// Collects the serial SFFT bin stream, keeps bins 0..FREQS-1 as saturated
// L1 magnitudes and publishes each complete frame as the parallel fft_in
// array with a one-cycle valid_in strobe. A fill buffer and a pending buffer
// double-buffer the frames so the source never stalls; a hold-off counter
// spaces valid_in strobes at least HOLDOFF cycles apart.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : spectrum_framer_if.slave (bin stream in, frame out)
//   dbg_state : current FSM state
// Optional feature: FRAMER_ZERO_DC_EN defined forces fill[0] to 0.
// Assumes 2 <= FREQS < NFFT.

module spectrum_framer
  import spectrum_framer_pkg::*;
#(
  parameter int NFFT    = `NFFT,
  parameter int FREQS   = `FREQS,
  parameter int IN_W    = `SFFT_OUTPUT_WIDTH,
  parameter int AMPL_W  = `INPUT_AMPL_WIDTH,
  parameter int HOLDOFF = 32
) (
  input  logic                clk,
  input  logic                reset,
  spectrum_framer_if.slave    bus,
  output state_t              dbg_state
);

  localparam int IDX_W = $clog2(NFFT);
  localparam int KW    = $clog2(FREQS);
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  localparam logic [IDX_W-1:0] LAST_KEPT = IDX_W'(FREQS - 1);
  localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(NFFT - 1);
  localparam logic [HO_W-1:0]  HOLD_LOAD = HO_W'(HOLDOFF - 1);

  typedef logic signed [AMPL_W-1:0] word_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cur_idx;
  logic [KW-1:0]    fill_addr;
  logic [HO_W-1:0]  hold;
  logic             pend;
  logic             publish;
  logic             complete;
  logic             restart;
  logic             fill_we;
  logic             valid_q;
  logic             drop_q;
  word_t            mag;
  word_t            fill_val;
  word_t            fill     [FREQS];
  word_t            pend_buf [FREQS];
  word_t            fft_q    [FREQS];

  l1_magnitude #(
    .IN_W   (IN_W),
    .AMPL_W (AMPL_W)
  ) u_mag (
    .re  (bus.bin_re),
    .im  (bus.bin_im),
    .mag (mag)
  );

  // Index of the bin on the bus this cycle: sop forces bin 0, otherwise
  // one past the previous accepted bin.
  assign cur_idx   = bus.bin_sop ? '0 : idx + IDX_W'(1);
  assign fill_addr = cur_idx[KW-1:0];

`ifdef FRAMER_ZERO_DC_EN
  assign fill_val = (fill_addr == '0) ? '0 : mag;
`else
  assign fill_val = mag;
`endif

  assign publish = pend && (hold == '0);

  always_comb begin
    next_state = state;
    fill_we    = 1'b0;
    complete   = 1'b0;
    restart    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.bin_valid && bus.bin_sop) begin
          fill_we    = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        if (bus.bin_valid) begin
          fill_we = 1'b1;
          if (bus.bin_sop) begin
            restart = 1'b1;
          end else if (cur_idx == LAST_KEPT) begin
            next_state = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (bus.bin_valid) begin
          if (bus.bin_sop) begin
            restart    = 1'b1;
            fill_we    = 1'b1;
            next_state = FILL;
          end else if (cur_idx == LAST_BIN) begin
            complete   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      pend    <= 1'b0;
      hold    <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      for (int i = 0; i < FREQS; i++) fft_q[i] <= '0;
    end else begin
      state   <= next_state;
      if (bus.bin_valid) idx <= cur_idx;
      valid_q <= publish;
      // A completed frame only drops the pending one if that pending frame
      // is not leaving on this same edge.
      drop_q  <= restart | (complete & pend & ~publish);
      if (publish) begin
        for (int i = 0; i < FREQS; i++) fft_q[i] <= pend_buf[i];
        hold <= HOLD_LOAD;
      end else if (hold != '0) begin
        hold <= hold - HO_W'(1);
      end
      if (complete) begin
        pend <= 1'b1;
      end else if (publish) begin
        pend <= 1'b0;
      end
    end
  end

  // Frame buffers carry no reset; pend qualifies their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FREQS; i++) begin
      if (fill_we && (fill_addr == KW'(i))) fill[i] <= fill_val;
    end
    if (complete) begin
      for (int i = 0; i < FREQS; i++) pend_buf[i] <= fill[i];
    end
  end

  assign bus.fft_in     = fft_q;
  assign bus.valid_in   = valid_q;
  assign bus.frame_drop = drop_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_spectrum_framer.sv
`timescale 1ns/1ps
module tb_spectrum_framer;
  import spectrum_framer_pkg::*;

  localparam int NFFT   = 32;
  localparam int FREQS  = 16;
  localparam int IN_W   = 16;
  localparam int AMPL_W = 16;
  localparam int HO1    = 32;
  localparam int HO2    = 100;
  localparam int LIM    = (1 << (AMPL_W - 1)) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  spectrum_framer_if #(.IN_W(IN_W), .AMPL_W(AMPL_W), .FREQS(FREQS)) bus1 ();
  spectrum_framer_if #(.IN_W(IN_W), .AMPL_W(AMPL_W), .FREQS(FREQS)) bus2 ();

  logic                   bin_valid = 1'b0;
  logic                   bin_sop   = 1'b0;
  logic                   sel2      = 1'b0;
  logic signed [IN_W-1:0] bin_re    = '0;
  logic signed [IN_W-1:0] bin_im    = '0;

  assign bus1.bin_valid = bin_valid & ~sel2;
  assign bus2.bin_valid = bin_valid & sel2;
  assign bus1.bin_sop   = bin_sop;
  assign bus2.bin_sop   = bin_sop;
  assign bus1.bin_re    = bin_re;
  assign bus2.bin_re    = bin_re;
  assign bus1.bin_im    = bin_im;
  assign bus2.bin_im    = bin_im;

  state_t st1;
  state_t st2;

  spectrum_framer #(.NFFT(NFFT), .FREQS(FREQS), .IN_W(IN_W), .AMPL_W(AMPL_W), .HOLDOFF(HO1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state(st1));

  spectrum_framer #(.NFFT(NFFT), .FREQS(FREQS), .IN_W(IN_W), .AMPL_W(AMPL_W), .HOLDOFF(HO2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .dbg_state(st2));

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // ---------------- reference model ----------------
  int re_a [NFFT];
  int im_a [NFFT];
  int exp_a [FREQS];

  function automatic int mag_model(input int re, input int im);
    int m;
    m = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    return (m > LIM) ? LIM : m;
  endfunction

  // mode 0: re=k, im=-1; mode 1: random; mode 2: random with bin 3 at the
  // most negative value on both components.
  task automatic gen_frame(input int mode);
    for (int k = 0; k < NFFT; k++) begin
      if (mode == 0) begin
        re_a[k] = k;
        im_a[k] = -1;
      end else if ($urandom_range(0, 3) == 0) begin
        re_a[k] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
        im_a[k] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
      end else begin
        re_a[k] = int'($urandom_range(0, 2000)) - 1000;
        im_a[k] = int'($urandom_range(0, 2000)) - 1000;
      end
    end
    if (mode == 2) begin
      re_a[3] = -(1 << (IN_W - 1));
      im_a[3] = -(1 << (IN_W - 1));
    end
    for (int k = 0; k < FREQS; k++) exp_a[k] = mag_model(re_a[k], im_a[k]);
`ifdef FRAMER_ZERO_DC_EN
    exp_a[0] = 0;
`endif
  endtask

  // scoreboard: FREQS expected words per frame, in publish order
  logic [AMPL_W-1:0] exp_q[$];

  task automatic push_exp();
    for (int k = 0; k < FREQS; k++) exp_q.push_back(AMPL_W'(exp_a[k]));
  endtask

  // ---------------- drivers ----------------
  int last_cyc = 0;

  task automatic send_bins(input int lo, input int hi, input bit gaps);
    for (int k = lo; k < hi; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          bin_valid = 1'b0;
          bin_sop   = 1'b0;
        end
      end
      @(negedge clk);
      bin_valid = 1'b1;
      bin_sop   = (k == 0);
      bin_re    = IN_W'(re_a[k]);
      bin_im    = IN_W'(im_a[k]);
      last_cyc  = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bin_valid = 1'b0;
      bin_sop   = 1'b0;
    end
  endtask

  // ---------------- monitors ----------------
  int pulses1 = 0;
  int drops1  = 0;
  int pcyc1 [$];

  always @(negedge clk) begin
    if (bus1.frame_drop === 1'b1) drops1++;
    if (bus1.valid_in === 1'b1) begin
      pulses1++;
      pcyc1.push_back(cyc);
      check("frame_expected", 32'(exp_q.size() >= FREQS), 32'd1);
      if (exp_q.size() >= FREQS) begin
        for (int i = 0; i < FREQS; i++) begin
          logic [AMPL_W-1:0] e;
          e = exp_q.pop_front();
          check($sformatf("fft_in[%0d]", i), 32'($unsigned(bus1.fft_in[i])), 32'(e));
        end
      end
    end
  end

  int pulses2 = 0;
  int drops2  = 0;
  int pcyc2 [$];
  logic [AMPL_W-1:0] snap_a [FREQS];
  logic [AMPL_W-1:0] snap_b [FREQS];

  always @(negedge clk) begin
    if (bus2.frame_drop === 1'b1) drops2++;
    if (bus2.valid_in === 1'b1) begin
      for (int i = 0; i < FREQS; i++) begin
        if (pulses2 == 0) snap_a[i] = bus2.fft_in[i];
        else if (pulses2 == 1) snap_b[i] = bus2.fft_in[i];
      end
      pcyc2.push_back(cyc);
      pulses2++;
    end
  end

  task automatic wait_pulses1(input int target, input int budget);
    int n;
    n = 0;
    while (pulses1 < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("pulse_count", 32'(pulses1), 32'(target));
  endtask

  // ---------------- directed sequence ----------------
  int p0, d0, l1, l2, base;
  int exp_f1 [FREQS];
  int exp_f3 [FREQS];

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("reset_valid_in", 32'(bus1.valid_in), 32'd0);
    check("reset_frame_drop", 32'(bus1.frame_drop), 32'd0);
    check("reset_state", 32'(st1), 32'(IDLE));
    for (int i = 0; i < FREQS; i++)
      check($sformatf("reset_fft_in[%0d]", i), 32'($unsigned(bus1.fft_in[i])), 32'd0);

    // ramp frame, latency from last bin to strobe
    gen_frame(0);
    push_exp();
    send_bins(0, NFFT, 1'b0);
    idle(1);
    wait_pulses1(1, 20);
    check("latency_ramp", 32'(pcyc1[0]), 32'(last_cyc + 2));
    check("drops_ramp", 32'(drops1), 32'd0);
    idle(50);

    // saturation of bin 3
    gen_frame(2);
    push_exp();
    send_bins(0, NFFT, 1'b0);
    idle(1);
    wait_pulses1(2, 20);
    check("sat_bin3", 32'($unsigned(bus1.fft_in[3])), 32'(LIM));
    idle(50);

    // two back-to-back frames
    d0 = drops1;
    p0 = pulses1;
    gen_frame(1);
    push_exp();
    send_bins(0, NFFT, 1'b0);
    l1 = last_cyc;
    gen_frame(1);
    push_exp();
    send_bins(0, NFFT, 1'b0);
    idle(1);
    wait_pulses1(p0 + 2, 80);
    check("b2b_first_latency", 32'(pcyc1[p0]), 32'(l1 + 2));
    check("b2b_spacing", 32'(pcyc1[p0 + 1] - pcyc1[p0]), 32'(HO1));
    check("b2b_no_drop", 32'(drops1 - d0), 32'd0);
    idle(50);

    // restart at idx 10
    d0 = drops1;
    p0 = pulses1;
    gen_frame(1);
    send_bins(0, 10, 1'b0);
    gen_frame(1);
    push_exp();
    send_bins(0, NFFT, 1'b0);
    idle(1);
    wait_pulses1(p0 + 1, 20);
    check("restart_drop", 32'(drops1 - d0), 32'd1);
    idle(50);

    // reset at idx 20
    d0 = drops1;
    p0 = pulses1;
    gen_frame(1);
    send_bins(0, 20, 1'b0);
    @(negedge clk);
    bin_valid = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid_in", 32'(bus1.valid_in), 32'd0);
    check("rst_state", 32'(st1), 32'(IDLE));
    for (int i = 0; i < FREQS; i++)
      check($sformatf("rst_fft_in[%0d]", i), 32'($unsigned(bus1.fft_in[i])), 32'd0);
    idle(60);
    check("rst_no_pulse", 32'(pulses1 - p0), 32'd0);
    check("rst_no_drop", 32'(drops1 - d0), 32'd0);
    gen_frame(1);
    push_exp();
    send_bins(0, NFFT, 1'b0);
    idle(1);
    wait_pulses1(p0 + 1, 20);
    check("post_rst_latency", 32'(pcyc1[p0]), 32'(last_cyc + 2));
    idle(50);

    // random gaps in the bin stream
    p0 = pulses1;
    gen_frame(1);
    push_exp();
    send_bins(0, NFFT, 1'b1);
    idle(1);
    wait_pulses1(p0 + 1, 20);
    check("gap_latency", 32'(pcyc1[p0]), 32'(last_cyc + 2));
    idle(10);

    // long hold-off instance: three back-to-back frames
    sel2 = 1'b1;
    idle(2);
    gen_frame(1);
    for (int k = 0; k < FREQS; k++) exp_f1[k] = exp_a[k];
    send_bins(0, NFFT, 1'b0);
    l2 = last_cyc;
    gen_frame(1);
    send_bins(0, NFFT, 1'b0);
    gen_frame(1);
    for (int k = 0; k < FREQS; k++) exp_f3[k] = exp_a[k];
    send_bins(0, NFFT, 1'b0);
    idle(150);
    check("ho_pulses", 32'(pulses2), 32'd2);
    check("ho_drops", 32'(drops2), 32'd1);
    if (pulses2 >= 2) begin
      base = pcyc2[0];
      check("ho_first_latency", 32'(base), 32'(l2 + 2));
      check("ho_spacing", 32'(pcyc2[1] - base), 32'(HO2));
      for (int k = 0; k < FREQS; k++) begin
        check($sformatf("ho_f1[%0d]", k), 32'(snap_a[k]), 32'(exp_f1[k]));
        check($sformatf("ho_f3[%0d]", k), 32'(snap_b[k]), 32'(exp_f3[k]));
      end
    end
    sel2 = 1'b0;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spectrum_framer.md
# spectrum_framer

Producer-side front end for the peak finder: collects the serial complex bin stream from the SFFT, converts each kept bin to an L1 magnitude, and presents one complete frame as the parallel `fft_in[FREQS]` array with a one-cycle `valid_in` strobe. It sits between the SFFT core and `peaks`. Frames are double-buffered, so the SFFT never stalls. A hold-off counter keeps `valid_in` pulses far enough apart for the sequential peak search to finish.

## Interface
Parameters:
- `NFFT`, default `` `NFFT ``: bins per input frame, power of 2.
- `FREQS`, default `` `FREQS ``: bins kept per frame (bins 0..FREQS-1).
- `IN_W`, default `` `SFFT_OUTPUT_WIDTH ``: signed width of the re/im inputs.
- `AMPL_W`, default `` `INPUT_AMPL_WIDTH ``: signed width of each `fft_in` element.
- `HOLDOFF`, default 32: minimum number of cycles from one `valid_in` to the next.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `bin_valid`  in  1  a bin is present this cycle.
- `bin_sop`  in  1  qualifies bin 0 of a frame; ignored unless `bin_valid` is high.
- `bin_re`, `bin_im`  in  IN_W each, signed  bin value.
- `fft_in[FREQS]`  out  AMPL_W each, signed  published frame.
- `valid_in`  out  1  one-cycle strobe: `fft_in` holds a new frame.
- `frame_drop`  out  1  one-cycle strobe: a frame was lost.

## Operation
- Magnitude: mag = |re| + |im|.
  - Computed as IN_W+1-bit unsigned.
  - |-2^(IN_W-1)| = 2^(IN_W-1); no wrap.
  - Saturated to 2^(AMPL_W-1)-1 before storing.
- Bin index counter, log2(NFFT) bits.
  - Cleared by any `bin_valid` with `bin_sop` high; that bin is bin 0.
  - Otherwise incremented on each `bin_valid`.
- FSM states:
  - IDLE: waits for `bin_valid` with `bin_sop`; that bin is written to fill[0]; go to FILL.
  - FILL: bins 1..FREQS-1 are written to fill[idx]. After bin FREQS-1, go to DISCARD.
  - DISCARD: bins FREQS..NFFT-1 are dropped. The bin with idx=NFFT-1 completes the frame; go to IDLE.
- Frame completion:
  - The fill buffer is copied to the pending buffer and `pend` is set.
  - If `pend` was already set, the old pending frame is overwritten and `frame_drop` pulses.
- Publish: when `pend` is set and the hold-off count is 0:
  - `fft_in` <= pending buffer, `valid_in` pulses, `pend` clears, hold-off loads HOLDOFF-1.
  - Otherwise the hold-off count decrements while nonzero.
- Restart: `bin_sop` in FILL or DISCARD restarts the frame at bin 0 and pulses `frame_drop` (truncated frame). This covers `bin_sop` on what would be bin NFFT-1.
- Gaps: `bin_valid` low stalls the frame without timeout.
- `fft_in` holds its value between strobes.

## Timing
- Reset values:
  - FSM in IDLE; bin index 0; `pend` 0; hold-off 0.
  - All `fft_in` 0; `valid_in` 0; `frame_drop` 0.
  - Fill and pending buffers are not reset.
- Reset mid-frame discards the partial frame and any pending frame without a `frame_drop`.
- Latency:
  - Bin on the cycle-t edge: fill register updated at t+1.
  - Last bin (idx NFFT-1) accepted at edge t with hold-off 0: pending captured at t+1, `valid_in` high in cycle t+1 → t+2 with `fft_in` valid in the same cycle. Two-stage path.
- Spacing: consecutive `valid_in` rising edges are at least HOLDOFF cycles apart.
- Same-edge collision (frame completes while `pend` publishes): publish takes the old pending frame; the new frame becomes pending with no drop.

## Configuration
- `FRAMER_ZERO_DC_EN` defined: fill[0] is always written 0 (DC bin suppressed).
- `FRAMER_ZERO_DC_EN` undefined: bin 0 is stored as its computed magnitude like every other bin.

## Structure
- Shared package:
  - `ampl_t` (signed AMPL_W).
  - `bin_idx_t`.
  - The FSM state enum {IDLE, FILL, DISCARD}.
  - Saturation limit constant AMPL_MAX = 2^(AMPL_W-1)-1.
- One sub-module, `l1_magnitude`: combinational abs/add/saturate, parameterized on IN_W and AMPL_W.
- FSM, buffers and hold-off stay in the top level.

## Test plan
Defaults NFFT=32, FREQS=16, HOLDOFF=32 unless a line says otherwise.
- After reset, one frame with bin k re=k, im=-1 and no gaps → single `valid_in`; `fft_in[k]` = k+1 for k=1..15; `fft_in[0]`=1, or 0 with the macro.
- Bin 3 re=-2^(IN_W-1), im=-2^(IN_W-1), AMPL_W=IN_W → `fft_in[3]` = 2^(AMPL_W-1)-1.
- Two back-to-back frames, 32 cycles each → two `valid_in` pulses exactly 32 cycles apart; second frame correct; no `frame_drop`.
- HOLDOFF=100, three back-to-back frames → second frame dropped (`frame_drop` once); third frame published 100 cycles after the first.
- `bin_sop` reasserted at idx 10 → `frame_drop` pulse; next `valid_in` carries the restarted frame only.
- `reset` asserted at idx 20 → no `valid_in`; outputs 0; next full frame publishes normally.
